inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the encoded-instruction counter.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request fields valid.
REQ-005 in_ready  output  1  encoder accepts request this cycle.
REQ-006 fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
REQ-007 opcode  input  7  placed in inst[6:0].
REQ-008 rd, rs1, rs2  input  5 each  register fields.
REQ-009 funct3  input  3; funct7  input  7  function fields.
REQ-010 imm  input  32  immediate value, byte-offset form, sign-extended.
REQ-011 out_valid  output  1  inst/imm_err valid.
REQ-012 out_ready  input  1  consumer accepts output.
REQ-013 inst  output  32  encoded instruction word.
REQ-014 imm_err  output  1  immediate not encodable or fmt illegal.
REQ-015 enc_count  output  CNT_W  completed output handshakes.

Function
REQ-016 Two-stage pipeline: S1 registers request fields; S2 registers packed inst and imm_err; latency 2 cycles from accept to out_valid with out_ready held high.
REQ-017 Accept on in_valid&&in_ready; output transfer on out_valid&&out_ready.
REQ-018 S2 advances when !out_valid||out_ready; S1 advances when S2 advances; in_ready = !s1_valid || S2 advances (combinational, no input-to-ready path through in_valid).
REQ-019 Full throughput: one request per cycle sustained when out_ready stays high; no loss or duplication under any out_ready pattern; order preserved.
REQ-020 inst/imm_err held stable while out_valid&&!out_ready.
REQ-021 R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode.
REQ-022 I: imm[11:0] to [31:20]; exception: opcode 0010011 with funct3 101 puts funct7 in [31:25], imm[4:0] in [24:20].
REQ-023 S: imm[11:5] to [31:25], imm[4:0] to [11:7].
REQ-024 B: imm[12]->31, imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->7; imm[0] dropped.
REQ-025 U: imm[31:12] to [31:12]. J: imm[20]->31, imm[10:1]->[30:21], imm[11]->20, imm[19:12]->[19:12].
REQ-026 Unused fields per format are taken from inputs (rs1/rs2/funct3/rd as applicable); fmt 6/7 gives inst=0, imm_err=1.
REQ-027 Round-trip: decoding inst's immediate yields imm for every encodable value.
REQ-028 enc_count increments by 1 per output transfer, wraps 2^CNT_W-1 -> 0.

Reset
REQ-029 rst_n low: s1_valid=0, out_valid=0, inst=0, imm_err=0, enc_count=0 immediately; in_ready=1 while reset is asserted and after release.
REQ-030 Reset mid-operation discards all in-flight requests; none emerge after release.

Configuration
REQ-031 Macro INST_ENCODER_RANGE_CHECK_EN defined: imm_err=1 when I/S imm outside signed 12-bit; B outside signed 13-bit or imm[0]=1; J outside signed 21-bit or imm[0]=1; U imm[11:0]!=0; shift-immediate imm[31:5]!=0. inst is still packed from truncated bits.
REQ-032 Macro undefined: imm_err=1 only for illegal fmt; immediates silently truncated.

Structure
REQ-033 Shared package riscv_enc_pkg: fmt encoding constants, opcode constants (LOAD, OP_IMM, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP).
REQ-034 Combinational sub-module imm_pack (fields+fmt -> inst, imm_err) instantiated between S1 and S2.

Verification
REQ-035 I, opcode 0010011, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> inst 0xFFF00093, imm_err=0, 2 cycles later.
REQ-036 B, opcode 1100011, rs1=rs2=0, f3=0, imm=-4 -> inst 0xFE000EE3; U, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-037 J, opcode 1101111, rd=1, imm=0x800 -> 0x001000EF; with macro, I imm=2048 -> imm_err=1; without macro -> imm_err=0.
REQ-038 Three back-to-back requests, out_ready low 4 cycles -> in_ready low after 2 accepts, outputs held stable, all three delivered in order, enc_count=3.
REQ-039 rst_n pulsed low with 2 requests in flight -> out_valid=0, enc_count=0, no stale output after release; fmt=7 -> inst=0, imm_err=1.

Source files
------------

// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: format/opcode constants, request record and immediate range helper
package riscv_enc_pkg;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_req_t;

   // true when v is representable as a w-bit two's-complement value
   function automatic logic fits_s(input logic [31:0] v, input int w);
      logic [31:0] hi;
      hi = $signed(v) >>> (w - 1);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational packing of request fields into a 32-bit instruction word.
// Build option INST_ENCODER_RANGE_CHECK_EN flags immediates that do not fit their format.
module imm_pack
   import riscv_enc_pkg::*;
(
   input  enc_req_t    req_i,
   output logic [31:0] inst_o,
   output logic        imm_err_o
);

   logic        shift;
   logic        rng_err;
   logic [31:0] im;

   // scatter the immediate into the format's bit positions; flag illegal/unencodable requests
   always_comb begin
      im = req_i.imm;
      shift = (req_i.fmt == FMT_I) && (req_i.opcode == OPC_OP_IMM) && (req_i.funct3 == 3'b101);
      case (req_i.fmt)
         FMT_R:   inst_o = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
         FMT_I:   inst_o = shift ? {req_i.funct7, im[4:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode}
                                 : {im[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
         FMT_S:   inst_o = {im[11:5], req_i.rs2, req_i.rs1, req_i.funct3, im[4:0], req_i.opcode};
         FMT_B:   inst_o = {im[12], im[10:5], req_i.rs2, req_i.rs1, req_i.funct3, im[4:1], im[11], req_i.opcode};
         FMT_U:   inst_o = {im[31:12], req_i.rd, req_i.opcode};
         FMT_J:   inst_o = {im[20], im[10:1], im[11], im[19:12], req_i.rd, req_i.opcode};
         default: inst_o = '0;
      endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
      case (req_i.fmt)
         FMT_I:   rng_err = shift ? |im[31:5] : !fits_s(im, 12);
         FMT_S:   rng_err = !fits_s(im, 12);
         FMT_B:   rng_err = !fits_s(im, 13) || im[0];
         FMT_U:   rng_err = |im[11:0];
         FMT_J:   rng_err = !fits_s(im, 21) || im[0];
         default: rng_err = 1'b0;
      endcase
`else
      rng_err = 1'b0;
`endif
      imm_err_o = (req_i.fmt > FMT_J) || rng_err;
   end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage valid/ready pipeline turning instruction fields into encoded words.
// Build option INST_ENCODER_RANGE_CHECK_EN enables immediate range checking in imm_pack.
module inst_encoder
   import riscv_enc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fmt,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      inst,
   output logic             imm_err,
   output logic [CNT_W-1:0] enc_count
);

   enc_req_t         s1_req_q, s1_req_d;
   logic             s1_valid_q, s1_valid_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      inst_q, inst_d, pk_inst;
   logic             imm_err_q, imm_err_d, pk_err;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             adv;

   imm_pack u_pack (
      .req_i     (s1_req_q),
      .inst_o    (pk_inst),
      .imm_err_o (pk_err)
   );

   // stage advance rules and next-state for both stages and the transfer counter
   always_comb begin
      adv = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || adv;
      s1_valid_d = in_ready ? in_valid : s1_valid_q;
      s1_req_d = (in_ready && in_valid) ? '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                                            funct3: funct3, funct7: funct7, imm: imm} : s1_req_q;
      out_valid_d = adv ? s1_valid_q : out_valid_q;
      inst_d = (adv && s1_valid_q) ? pk_inst : inst_q;
      imm_err_d = (adv && s1_valid_q) ? pk_err : imm_err_q;
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, out_valid_q && out_ready};
   end

   // pipeline registers; reset drops anything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_req_q    <= '0;
         out_valid_q <= 1'b0;
         inst_q      <= '0;
         imm_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_req_q    <= s1_req_d;
         out_valid_q <= out_valid_d;
         inst_q      <= inst_d;
         imm_err_q   <= imm_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign inst      = inst_q;
   assign imm_err   = imm_err_q;
   assign enc_count = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized traffic against a scoreboard model, plus literal encodings and reset/backpressure scenarios
module tb_inst_encoder;

   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic        in_ready, out_valid, imm_err;
   logic [2:0]  fmt = 0, funct3 = 0;
   logic [6:0]  opcode = 0, funct7 = 0;
   logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
   logic [31:0] imm = 0, inst;
   logic [3:0]  enc_count;
   int          vectors = 0, miscompares = 0;
   bit          rnd_rdy = 0;

   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic [2:0]  fmt;
      logic        sh;
      logic [31:0] imm;
      logic        enc;
   } exp_t;

   exp_t        q[$];
   logic [3:0]  exp_cnt = 0;
   logic        held = 0, h_err;
   logic [31:0] h_inst;

   inst_encoder #(.CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
      .imm_err(imm_err), .enc_count(enc_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   function automatic bit is_shift(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3);
      return f == 1 && op == 7'b0010011 && f3 == 3'b101;
   endfunction

   function automatic bit out_of_range(input logic [2:0] f, input bit sh, input logic [31:0] v);
      int s;
      s = $signed(v);
      case (f)
         1: return sh ? (v >> 5) != 0 : (s < -2048 || s > 2047);
         2: return s < -2048 || s > 2047;
         3: return s < -4096 || s > 4095 || v[0];
         4: return v[11:0] != 0;
         5: return s < -1048576 || s > 1048575 || v[0];
         default: return 0;
      endcase
   endfunction

   function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                                  input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] v);
      exp_t e;
      logic [31:0] base, regs;
      e.fmt = f;
      e.imm = v;
      e.sh = is_shift(f, op, f3);
      base = (32'(rs1_or(s1)) << 15) | (32'(f3) << 12) | 32'(op);
      regs = base | (32'(s2) << 20);
      case (f)
         0: e.inst = regs | (32'(f7) << 25) | (32'(d) << 7);
         1: e.inst = base | (32'(d) << 7) | (e.sh ? ((32'(f7) << 25) | ((v & 31) << 20)) : ((v & 32'hFFF) << 20));
         2: e.inst = regs | (((v >> 5) & 127) << 25) | ((v & 31) << 7);
         3: e.inst = regs | (((v >> 12) & 1) << 31) | (((v >> 5) & 63) << 25) | (((v >> 1) & 15) << 8) | (((v >> 11) & 1) << 7);
         4: e.inst = (v & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
         5: e.inst = (((v >> 20) & 1) << 31) | (((v >> 1) & 1023) << 21) | (((v >> 11) & 1) << 20) | (v & 32'h000FF000) | (32'(d) << 7) | 32'(op);
         default: e.inst = 0;
      endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
      e.err = f > 5 || out_of_range(f, e.sh, v);
`else
      e.err = f > 5;
`endif
      e.enc = f >= 1 && f <= 5 && !out_of_range(f, e.sh, v);
      return e;
   endfunction

   function automatic logic [4:0] rs1_or(input logic [4:0] s);
      return s;
   endfunction

   function automatic logic [31:0] decode(input logic [2:0] f, input logic sh, input logic [31:0] w);
      case (f)
         1: return sh ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
         2: return {{20{w[31]}}, w[31:25], w[11:7]};
         3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         4: return {w[31:12], 12'd0};
         default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: every accepted request is modelled, every output transfer is checked in order
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         exp_cnt = 0;
         held = 0;
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_enc_count", 32'(enc_count), 0);
         chk("rst_in_ready", 32'(in_ready), 1);
      end else begin
         chk("enc_count", 32'(enc_count), 32'(exp_cnt));
         if (held) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_inst", inst, h_inst);
            chk("hold_err", 32'(imm_err), 32'(h_err));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_output: got inst %h expected no output at %0t", inst, $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("inst", inst, e.inst);
               chk("imm_err", 32'(imm_err), 32'(e.err));
               if (e.enc) chk("roundtrip", decode(e.fmt, e.sh, inst), e.imm);
            end
            exp_cnt++;
         end
         held = out_valid && !out_ready;
         h_inst = inst;
         h_err = imm_err;
         if (in_valid && in_ready) q.push_back(model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] v);
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = v;
      in_valid = 1;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
      end
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic lit(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] v,
                      input logic [31:0] x_inst, input logic x_err);
      exp_t m;
      m = model(f, op, d, s1, s2, f3, f7, v);
      chk("model_inst", m.inst, x_inst);
      chk("model_err", 32'(m.err), 32'(x_err));
      out_ready = 1;
      send(f, op, d, s1, s2, f3, f7, v);
      idle(1);
      chk("lit_valid", 32'(out_valid), 1);
      chk("lit_inst", inst, x_inst);
      chk("lit_err", 32'(imm_err), 32'(x_err));
      idle(2);
   endtask

   initial begin
      idle(2);
      #1;
      chk("rst_inst", inst, 0);
      chk("rst_imm_err", 32'(imm_err), 0);
      rst_n = 1;
      idle(1);
      lit(1, 7'b0010011, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 0);
      lit(3, 7'b1100011, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFE000EE3, 0);
      lit(4, 7'b0110111, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 0);
      lit(5, 7'b1101111, 1, 0, 0, 0, 0, 32'h00000800, 32'h001000EF, 0);
`ifdef INST_ENCODER_RANGE_CHECK_EN
      lit(1, 7'b0010011, 0, 0, 0, 0, 0, 32'd2048, 32'h80000013, 1);
`else
      lit(1, 7'b0010011, 0, 0, 0, 0, 0, 32'd2048, 32'h80000013, 0);
`endif
      lit(1, 7'b0010011, 2, 3, 0, 5, 7'h20, 32'd7, 32'h4071D113, 0);
      lit(2, 7'b0100011, 0, 2, 1, 2, 0, 32'hFFFFFFF8, 32'hFE112C23, 0);
      lit(7, 7'b0110011, 3, 4, 5, 1, 7'h7F, 32'h12345678, 32'h00000000, 1);
      // reset with two requests in flight
      out_ready = 0;
      send(0, 7'b0110011, 1, 2, 3, 0, 0, 0);
      send(0, 7'b0110011, 4, 5, 6, 0, 0, 0);
      rst_n = 0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_enc_count", 32'(enc_count), 0);
      chk("midrst_inst", inst, 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      idle(1);
      rst_n = 1;
      out_ready = 1;
      idle(5);
      chk("post_rst_idle", 32'(out_valid), 0);
      // backpressure: three back-to-back requests with the consumer stalled
      out_ready = 0;
      send(0, 7'b0110011, 1, 1, 1, 1, 1, 0);
      send(1, 7'b0000011, 2, 2, 2, 2, 2, 32'h7FF);
      chk("bp_in_ready", 32'(in_ready), 0);
      fork
         begin
            idle(4);
            out_ready = 1;
         end
      join_none
      send(2, 7'b0100011, 3, 3, 3, 3, 3, 32'hFFFFF800);
      idle(4);
      chk("bp_enc_count", 32'(enc_count), 3);
      // randomized traffic with random consumer stalls
      rnd_rdy = 1;
      repeat (600) begin
         logic [2:0] f, f3;
         logic [6:0] op;
         logic [31:0] v;
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
         op = 7'($urandom);
         f3 = 3'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            op = 7'b0010011;
            f3 = 3'b101;
         end
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: v = 32'($urandom_range(0, 31));
            default: v = $urandom & 32'hFFFFF000;
         endcase
         send(f, op, 5'($urandom), 5'($urandom), 5'($urandom), f3, 7'($urandom), v);
      end
      rnd_rdy = 0;
      out_ready = 1;
      idle(6);
      chk("drain", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
